bcd_event_counter: RTL and testbench

//  Parametrised N-digit BCD event counter with integrated active-low seven-segment decode.

---
 rtl/bcd_event_counter_pkg.sv | 31 +++
 rtl/bcd_event_counter_if.sv | 28 ++
 rtl/bcd_event_counter_digit_cell.sv | 43 ++++
 rtl/bcd_event_counter.sv | 106 ++++++++++
 tb/tb_bcd_event_counter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_event_counter_pkg.sv
// Shared BCD types and decode helpers for the event counter and its digit cells.
// Seven-segment patterns are active-low with bit 0 = segment a.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg7(bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h18;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic bcd_t bcd_clamp(bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_event_counter_if.sv
// Control and display bundle of the BCD event counter; the master drives the
// event/control side and the slave (the counter) drives count, segments and flags.
interface bcd_event_counter_if #(
  parameter int unsigned DIGITS = 2
);

  logic                  en;
  logic                  event_in;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic [7*DIGITS-1:0]   seg;
  logic                  at_max;
  logic                  ovf_pulse;
  logic                  ovf_flag;

  modport master (
    output en, event_in, clear, load, load_val,
    input  count, seg, at_max, ovf_pulse, ovf_flag
  );

  modport slave (
    input  en, event_in, clear, load, load_val,
    output count, seg, at_max, ovf_pulse, ovf_flag
  );

endinterface

// File: rtl/bcd_event_counter_digit_cell.sv
// One BCD digit of the ripple counter: clear > load (clamped) > increment,
// carrying out when a 9 rolls over to 0.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  bcd_t load_d,
  input  logic cin,
  output bcd_t q,
  output logic cout
);

  bcd_t q_q;
  bcd_t q_d;
  logic is_nine;

  always_comb begin
    is_nine = (q_q == 4'd9);
    cout    = cin & is_nine;
    q_d     = q_q;
    if (clear) begin
      q_d = '0;
    end else if (load) begin
      q_d = bcd_clamp(load_d);
    end else if (cin) begin
      q_d = is_nine ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_event_counter.sv
// N-digit BCD event counter: rising-edge event detect, clear/load, wrap or
// saturate on overflow, sticky overflow flag and active-low 7-segment decode.
module bcd_event_counter #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned WRAP     = 1,
  parameter int unsigned BLANK_LZ = 0
) (
  input logic                 clk,
  input logic                 reset,
  bcd_event_counter_if.slave  bus
);

  import bcd_pkg::*;

  localparam logic        SAT = (WRAP == 0);
  localparam int unsigned CW  = 4 * DIGITS;

  logic          event_prev_q, event_prev_d;
  logic          ovf_pulse_q,  ovf_pulse_d;
  logic          ovf_flag_q,   ovf_flag_d;
  logic          at_max_q,     at_max_d;
  logic          inc;
  logic          cin0;
  logic          load_all9;
  logic          next_is_max;
  logic [DIGITS:0] carry;
  logic [CW-1:0]   count;

  assign inc      = bus.en & bus.event_in & ~event_prev_q;
  // In saturate mode the chain is never fed at all-9s, so the count holds.
  assign cin0     = inc & ~(at_max_q & SAT);
  assign carry[0] = cin0;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk    (clk),
      .reset  (reset),
      .clear  (bus.clear),
      .load   (bus.load),
      .load_d (bus.load_val[4*i +: 4]),
      .cin    (carry[i]),
      .q      (count[4*i +: 4]),
      .cout   (carry[i+1])
    );
  end

  // at_max is predicted from the same-edge inputs so it stays a plain flop.
  always_comb begin
    load_all9   = 1'b1;
    next_is_max = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] < 4'd9) begin
        load_all9 = 1'b0;
      end
      if (count[4*i +: 4] != ((i == 0) ? 4'd8 : 4'd9)) begin
        next_is_max = 1'b0;
      end
    end
  end

  always_comb begin
    event_prev_d = bus.event_in;
    ovf_pulse_d  = ~bus.clear & ~bus.load & (carry[DIGITS] | (inc & at_max_q & SAT));
    ovf_flag_d   = ovf_flag_q | ovf_pulse_d;
    at_max_d     = at_max_q;
    if (bus.clear) begin
      ovf_flag_d = 1'b0;
      at_max_d   = 1'b0;
    end else if (bus.load) begin
      ovf_flag_d = 1'b0;
      at_max_d   = load_all9;
    end else if (inc) begin
      at_max_d   = at_max_q ? SAT : next_is_max;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_prev_q <= 1'b0;
      ovf_pulse_q  <= 1'b0;
      ovf_flag_q   <= 1'b0;
      at_max_q     <= 1'b0;
    end else begin
      event_prev_q <= event_prev_d;
      ovf_pulse_q  <= ovf_pulse_d;
      ovf_flag_q   <= ovf_flag_d;
      at_max_q     <= at_max_d;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    logic blank;
    if (BLANK_LZ != 0 && i > 0) begin : g_lz
      assign blank = (count[CW-1:4*i] == '0);
    end else begin : g_lit
      assign blank = 1'b0;
    end
    assign bus.seg[7*i +: 7] = blank ? SEG_BLANK : seg7(count[4*i +: 4]);
  end

  assign bus.count     = count;
  assign bus.at_max    = at_max_q;
  assign bus.ovf_pulse = ovf_pulse_q;
  assign bus.ovf_flag  = ovf_flag_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Self-checking bench: three counter variants (wrap, saturate, 3-digit blanked)
// share one stimulus stream and are checked against an integer reference model.
module tb_bcd_event_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        ev = 1'b0;
  logic        clr = 1'b0;
  logic        ld = 1'b0;
  logic [11:0] ld_val = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_event_counter_if #(.DIGITS(2)) if_w ();
  bcd_event_counter_if #(.DIGITS(2)) if_s ();
  bcd_event_counter_if #(.DIGITS(3)) if_b ();

  assign if_w.en = en;  assign if_w.event_in = ev;  assign if_w.clear = clr;
  assign if_w.load = ld; assign if_w.load_val = ld_val[7:0];
  assign if_s.en = en;  assign if_s.event_in = ev;  assign if_s.clear = clr;
  assign if_s.load = ld; assign if_s.load_val = ld_val[7:0];
  assign if_b.en = en;  assign if_b.event_in = ev;  assign if_b.clear = clr;
  assign if_b.load = ld; assign if_b.load_val = ld_val;

  bcd_event_counter #(.DIGITS(2), .WRAP(1), .BLANK_LZ(0)) u_wrap (
    .clk(clk), .reset(reset), .bus(if_w.slave));
  bcd_event_counter #(.DIGITS(2), .WRAP(0), .BLANK_LZ(0)) u_sat (
    .clk(clk), .reset(reset), .bus(if_s.slave));
  bcd_event_counter #(.DIGITS(3), .WRAP(1), .BLANK_LZ(1)) u_blank (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  // Reference model: counts held as plain integers.
  localparam logic [6:0] TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h18};
  int m_dig   [3] = '{2, 2, 3};
  int m_wrap  [3] = '{1, 0, 1};
  int m_blank [3] = '{0, 0, 1};
  int m_cnt   [3];
  bit m_flag  [3];
  bit m_pulse [3];
  bit m_prev  [3];

  function automatic int pow10(int n);
    int r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic int bcd2int(logic [11:0] v, int d);
    int r = 0;
    for (int k = 0; k < d; k++) begin
      int nib = int'(v[4*k +: 4]);
      if (nib > 9) nib = 9;
      r = r + nib * pow10(k);
    end
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(int v, int d);
    logic [31:0] r = '0;
    for (int k = 0; k < d; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [31:0] exp_seg(int v, int d, int blank);
    logic [31:0] r = '0;
    for (int k = 0; k < d; k++) begin
      if (blank != 0 && k > 0 && v < pow10(k)) r[7*k +: 7] = 7'h7F;
      else r[7*k +: 7] = TBL[(v / pow10(k)) % 10];
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_flag[k] = 1'b0; m_pulse[k] = 1'b0; m_prev[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      int  maxv = pow10(m_dig[k]) - 1;
      bit  inc  = en & ev & ~m_prev[k];
      m_prev[k]  = ev;
      m_pulse[k] = 1'b0;
      if (clr) begin
        m_cnt[k] = 0; m_flag[k] = 1'b0;
      end else if (ld) begin
        m_cnt[k] = bcd2int(ld_val, m_dig[k]); m_flag[k] = 1'b0;
      end else if (inc) begin
        if (m_cnt[k] == maxv) begin
          m_pulse[k] = 1'b1; m_flag[k] = 1'b1;
          m_cnt[k] = (m_wrap[k] != 0) ? 0 : maxv;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    check("w.count", 32'(if_w.count), int2bcd(m_cnt[0], 2));
    check("w.seg", 32'(if_w.seg), exp_seg(m_cnt[0], 2, 0));
    check("w.at_max", 32'(if_w.at_max), 32'(m_cnt[0] == 99));
    check("w.ovf_pulse", 32'(if_w.ovf_pulse), 32'(m_pulse[0]));
    check("w.ovf_flag", 32'(if_w.ovf_flag), 32'(m_flag[0]));
    check("s.count", 32'(if_s.count), int2bcd(m_cnt[1], 2));
    check("s.seg", 32'(if_s.seg), exp_seg(m_cnt[1], 2, 0));
    check("s.at_max", 32'(if_s.at_max), 32'(m_cnt[1] == 99));
    check("s.ovf_pulse", 32'(if_s.ovf_pulse), 32'(m_pulse[1]));
    check("s.ovf_flag", 32'(if_s.ovf_flag), 32'(m_flag[1]));
    check("b.count", 32'(if_b.count), int2bcd(m_cnt[2], 3));
    check("b.seg", 32'(if_b.seg), exp_seg(m_cnt[2], 3, 1));
    check("b.at_max", 32'(if_b.at_max), 32'(m_cnt[2] == 999));
    check("b.ovf_pulse", 32'(if_b.ovf_pulse), 32'(m_pulse[2]));
    check("b.ovf_flag", 32'(if_b.ovf_flag), 32'(m_flag[2]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int r;
    // Reset held across one edge
    model_reset();
    #12;
    check_all();
    check("reset.b.seg", 32'(if_b.seg), 32'({7'h7F, 7'h7F, 7'h40}));
    reset = 1'b0;

    // Twelve pulses
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ev = 1'b1; tick();
      ev = 1'b0; tick();
    end
    check("t1.count", 32'(if_w.count), 32'h12);
    check("t1.seg", 32'(if_w.seg), 32'({7'h79, 7'h24}));

    // Held high counts once; disabled pulses ignored
    ev = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    ev = 1'b0; tick();
    check("t2.held", 32'(if_w.count), 32'h13);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ev = 1'b1; tick();
      ev = 1'b0; tick();
    end
    check("t2.en0", 32'(if_w.count), 32'h13);
    en = 1'b1;

    // Overflow: wrap vs saturate
    ld = 1'b1; ld_val = 12'h099; tick();
    ld = 1'b0; ev = 1'b1; tick();
    check("t3.wrap.count", 32'(if_w.count), 32'h00);
    check("t3.wrap.pulse", 32'(if_w.ovf_pulse), 32'h1);
    check("t3.sat.count", 32'(if_s.count), 32'h99);
    check("t3.sat.flag", 32'(if_s.ovf_flag), 32'h1);
    ev = 1'b0; tick();
    check("t3.wrap.pulse_end", 32'(if_w.ovf_pulse), 32'h0);
    check("t3.wrap.flag_sticky", 32'(if_w.ovf_flag), 32'h1);

    // Clear beats a coincident event; load clamps
    ld = 1'b1; ld_val = 12'h037; tick();
    ld = 1'b0; clr = 1'b1; ev = 1'b1; tick();
    check("t4.clear", 32'(if_w.count), 32'h00);
    clr = 1'b0; ev = 1'b0; tick();
    ld = 1'b1; ld_val = 12'h0A5; tick();
    ld = 1'b0;
    check("t4.clamp", 32'(if_w.count), 32'h95);

    // Leading-zero blanking
    ld = 1'b1; ld_val = 12'h007; tick();
    check("t5.blank", 32'(if_b.seg), 32'({7'h7F, 7'h7F, 7'h78}));
    ld_val = 12'h100; tick();
    check("t5.lit", 32'(if_b.seg), 32'({7'h79, 7'h40, 7'h40}));
    ld = 1'b0;

    // Asynchronous reset while an increment is pending
    ld = 1'b1; ld_val = 12'h009; tick();
    ld = 1'b0; ev = 1'b0; tick();
    ev = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b0;
    tick();
    check("t6.after", 32'(if_w.count), 32'h01);
    ev = 1'b0; tick();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 9) != 0);
      ev  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      r   = int'($urandom_range(0, 3));
      case (r)
        0:       ld_val = 12'h999;
        1:       ld_val = 12'h998;
        default: ld_val = 12'($urandom);
      endcase
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
